ctrl_fsm: RTL and testbench

Parametrised multi-cycle control sequencer for the 9-bit ISA datapath, between the instruction ROM, register file, ALU and data memory. It latches each instruction, decodes it into ALU op, register addresses, write enables and load/store strobes, and holds load/store operations until data memory signals completion. It also provides PC-advance and jump pulses, an optional zero-flag conditional jump, a sticky illegal-opcode flag, a halt state and a retired-instruction counter.

---
 rtl/ctrl_fsm.sv | 124 ++++++++++++
 tb/tb_ctrl_fsm.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control sequencer for the 9-bit ISA datapath.
// Inputs : Clk, Reset (sync, active-high), start, mach_code[IW], mem_ready, alu_zero.
// Outputs: Aluop, Ra, Rb, Wd, Jptr (decoded fields); WenR, WenD, Ldr, Str (enables);
//          pc_en, jump_en (PC control); busy, done, illegal (status); instr_count[CW].
// Option : CTRL_COND_JUMP_EN makes J conditional on alu_zero sampled in EXEC.
module ctrl_fsm #(
    parameter int IW  = 9,
    parameter int OPW = 4,
    parameter int RAW = 2,
    parameter int JPW = 3,
    parameter int CW  = 16
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           start,
    input  logic [IW-1:0]  mach_code,
    input  logic           mem_ready,
    input  logic           alu_zero,
    output logic [OPW-1:0] Aluop,
    output logic [RAW-1:0] Ra,
    output logic [RAW-1:0] Rb,
    output logic [RAW-1:0] Wd,
    output logic [JPW-1:0] Jptr,
    output logic           WenR,
    output logic           WenD,
    output logic           Ldr,
    output logic           Str,
    output logic           pc_en,
    output logic           jump_en,
    output logic           busy,
    output logic           done,
    output logic           illegal,
    output logic [CW-1:0]  instr_count
);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
    localparam logic [OPW-1:0] OP_RS   = OPW'(3);
    localparam logic [OPW-1:0] OP_LS   = OPW'(5);
    localparam logic [OPW-1:0] OP_AND  = OPW'(6);
    localparam logic [OPW-1:0] OP_OR   = OPW'(7);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(8);
    localparam logic [OPW-1:0] OP_LD   = OPW'(9);
    localparam logic [OPW-1:0] OP_STR  = OPW'(10);
    localparam logic [OPW-1:0] OP_J    = OPW'(11);
    localparam logic [OPW-1:0] OP_HALT = OPW'(15);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  ir;
    logic [OPW-1:0] op;
    logic [RAW-1:0] ra_f, rb_f;
    logic [JPW-1:0] jp_f;
    logic           is_alu, is_ld, is_str, is_j, is_halt, is_legal;
    logic           active, take_jump;

    assign op   = ir[OPW-1:0];
    assign ra_f = ir[OPW+RAW-1:OPW];
    assign rb_f = ir[OPW+2*RAW-1:OPW+RAW];
    assign jp_f = ir[OPW+JPW-1:OPW];

    assign is_alu   = op inside {OP_ADD, OP_ADDI, OP_RS, OP_LS, OP_AND, OP_OR, OP_XOR};
    assign is_ld    = op == OP_LD;
    assign is_str   = op == OP_STR;
    assign is_j     = op == OP_J;
    assign is_halt  = op == OP_HALT;
    assign is_legal = is_alu | is_ld | is_str | is_j | is_halt;

`ifdef CTRL_COND_JUMP_EN
    assign take_jump = alu_zero;
    logic unused_bits;
    assign unused_bits = ^ir;
`else
    assign take_jump = 1'b1;
    logic unused_bits;
    assign unused_bits = ^{ir, alu_zero};
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            ir          <= '0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nx;
            if (state == FETCH) ir <= mach_code;
            if (state == EXEC && !is_legal) illegal <= 1'b1;
            if (pc_en) instr_count <= instr_count + CW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? FETCH : IDLE;
            FETCH:   state_nx = EXEC;
            EXEC:    state_nx = (is_ld | is_str) ? MEM : is_halt ? HALT : FETCH;
            MEM:     state_nx = mem_ready ? FETCH : MEM;
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    // Decoded fields are only visible while the instruction is executing;
    // mem_ready and alu_zero qualify the retire/jump pulses in the same cycle
    // so that a ready memory costs no extra cycle.
    always_comb begin
        active  = state inside {EXEC, MEM};
        Aluop   = active ? op : '0;
        Ra      = active ? ra_f : '0;
        Rb      = active ? rb_f : '0;
        Wd      = (active && is_str) ? ra_f : '0;
        Ldr     = active && is_ld;
        Str     = active && is_str;
        WenD    = active && is_str;
        WenR    = (state == EXEC && is_alu) || (state == MEM && is_ld && mem_ready);
        pc_en   = (state == EXEC && !(is_ld || is_str)) || (state == MEM && mem_ready);
        jump_en = state == EXEC && is_j && take_jump;
        Jptr    = jump_en ? jp_f : '0;
        busy    = state inside {FETCH, EXEC, MEM};
        done    = state == HALT;
    end
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: randomized self-checking bench for ctrl_fsm against an instruction-level model.
module tb_ctrl_fsm;
    logic       Clk = 1'b0;
    logic       Reset, start, mem_ready, alu_zero;
    logic [8:0] mach_code;
    logic [3:0] Aluop;
    logic [1:0] Ra, Rb, Wd;
    logic [2:0] Jptr;
    logic       WenR, WenD, Ldr, Str, pc_en, jump_en, busy, done, illegal;
    logic [15:0] instr_count;
    logic [3:0] aluop2;
    logic [1:0] ra2, rb2, wd2;
    logic [2:0] jptr2;
    logic       wenr2, wend2, ldr2, str2, pc_en2, jump_en2, busy2, done2, illegal2;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;
    int m_count = 0;
    logic m_ill = 1'b0;

    always #5 Clk = ~Clk;

    ctrl_fsm dut (
        .Clk(Clk), .Reset(Reset), .start(start), .mach_code(mach_code),
        .mem_ready(mem_ready), .alu_zero(alu_zero),
        .Aluop(Aluop), .Ra(Ra), .Rb(Rb), .Wd(Wd), .Jptr(Jptr),
        .WenR(WenR), .WenD(WenD), .Ldr(Ldr), .Str(Str),
        .pc_en(pc_en), .jump_en(jump_en), .busy(busy), .done(done),
        .illegal(illegal), .instr_count(instr_count)
    );

    ctrl_fsm #(.CW(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .start(start), .mach_code(mach_code),
        .mem_ready(mem_ready), .alu_zero(alu_zero),
        .Aluop(aluop2), .Ra(ra2), .Rb(rb2), .Wd(wd2), .Jptr(jptr2),
        .WenR(wenr2), .WenD(wend2), .Ldr(ldr2), .Str(str2),
        .pc_en(pc_en2), .jump_en(jump_en2), .busy(busy2), .done(done2),
        .illegal(illegal2), .instr_count(cnt2)
    );

    logic [21:0] outs;
    assign outs = {Aluop, Ra, Rb, Wd, Jptr, WenR, WenD, Ldr, Str, pc_en, jump_en, busy, done, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [21:0] pk(input logic [3:0] a, input logic [1:0] ra, rb, wd,
                                       input logic [2:0] jp, input logic wr, wde, ld, st,
                                       input logic pc, je, bz, dn, il);
        return {a, ra, rb, wd, jp, wr, wde, ld, st, pc, je, bz, dn, il};
    endfunction

    task automatic cmp_all(input string tag, input logic [21:0] e);
        check(tag, 32'(outs), 32'(e));
        check({tag, "_cnt"}, 32'(instr_count), 32'(m_count % 65536));
        check({tag, "_cnt2"}, 32'(cnt2), 32'(m_count % 4));
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        start = 1'b0;
        m_count = 0;
        m_ill = 1'b0;
        #1 cmp_all("reset", '0);
    endtask

    task automatic do_start();
        tick();
        start = 1'b0;
        mem_ready = 1'($urandom);
        #1 cmp_all("idle", '0);
        tick();
        start = 1'b1;
        #1 cmp_all("idle_start", '0);
    endtask

    // Executes one instruction from its FETCH cycle; rst_mem asserts Reset in
    // the first MEM cycle and checks the IDLE state that follows.
    task automatic run_instr(input logic [8:0] ins, input int n_wait, input bit rst_mem);
        logic [3:0] opc;
        logic [1:0] ra, rb;
        logic [2:0] jp;
        logic alu, ld, st, jmp, hl, legal, z, take, rdy;
        opc = ins[3:0];
        ra = ins[5:4];
        rb = ins[7:6];
        jp = ins[6:4];
        alu = opc inside {4'd0, 4'd1, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8};
        ld = opc == 4'd9;
        st = opc == 4'd10;
        jmp = opc == 4'd11;
        hl = opc == 4'd15;
        legal = alu | ld | st | jmp | hl;
        tick();
        mach_code = ins;
        start = 1'($urandom);
        mem_ready = 1'($urandom);
        alu_zero = 1'($urandom);
        #1 cmp_all("fetch", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, m_ill));
        tick();
        mach_code = 9'($urandom);
        start = 1'($urandom);
        mem_ready = 1'($urandom);
        z = 1'($urandom);
        alu_zero = z;
`ifdef CTRL_COND_JUMP_EN
        take = jmp & z;
`else
        take = jmp;
`endif
        #1 cmp_all("exec", pk(opc, ra, rb, st ? ra : 2'd0, take ? jp : 3'd0, alu, st, ld, st,
                              !(ld | st), take, 1, 0, m_ill));
        if (ld | st) begin
            for (int k = 0; k <= n_wait; k++) begin
                tick();
                rdy = (k == n_wait) && !rst_mem;
                mem_ready = rdy;
                start = 1'($urandom);
                alu_zero = 1'($urandom);
                mach_code = 9'($urandom);
                Reset = rst_mem;
                #1 cmp_all("mem", pk(opc, ra, rb, st ? ra : 2'd0, 0, ld & rdy, st, ld, st,
                                     rdy, 0, 1, 0, m_ill));
                if (rst_mem) break;
            end
        end
        if (rst_mem) begin
            tick();
            Reset = 1'b0;
            start = 1'b0;
            m_count = 0;
            m_ill = 1'b0;
            #1 cmp_all("rst_mid_mem", '0);
        end else begin
            m_count++;
            if (!legal) m_ill = 1'b1;
        end
    endtask

    initial begin
        logic [8:0] ins;
        Reset = 1'b1;
        start = 1'b0;
        mach_code = '0;
        mem_ready = 1'b0;
        alu_zero = 1'b0;
        do_reset();
        do_start();
        run_instr(9'h060, 0, 0);
        run_instr(9'h0D9, 2, 0);
        run_instr(9'h03A, 0, 0);
        run_instr(9'h05B, 0, 0);
        for (int i = 0; i < 150; i++) begin
            ins = 9'($urandom);
            ins[3:0] = 4'($urandom_range(0, 14));
            run_instr(ins, $urandom_range(0, 3), 0);
        end
        do_reset();
        do_start();
        for (int i = 0; i < 5; i++) begin
            ins = 9'($urandom);
            ins[3:0] = 4'd0;
            run_instr(ins, 0, 0);
        end
        run_instr(9'h0D9, 0, 1);
        do_start();
        run_instr(9'h002, 0, 0);
        run_instr(9'h00F, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            start = 1'($urandom);
            mem_ready = 1'($urandom);
            #1 cmp_all("halt", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, m_ill));
        end
        check("halt_count", 32'(instr_count), 32'd2);
        check("halt_illegal", 32'(illegal), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
